// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared definitions for the MEM-stage load/store engine.
//   - SLCtrl access-size encodings (shared with the MEM/WB load extender)
//   - ExcCode constants (shared with the CP0/exception unit)
//   - FSM state encoding and an access-size decode helper
package mem_access_unit_pkg;

    // SLCtrl encodings; 5..7 are treated as word.
    localparam logic [2:0] SL_WORD   = 3'd0;
    localparam logic [2:0] SL_BYTE_U = 3'd1;
    localparam logic [2:0] SL_BYTE_S = 3'd2;
    localparam logic [2:0] SL_HALF_U = 3'd3;
    localparam logic [2:0] SL_HALF_S = 3'd4;

    // Memory exception codes.
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    function automatic size_t access_size(input logic [2:0] sl);
        case (sl)
            SL_BYTE_U, SL_BYTE_S: access_size = SZ_BYTE;
            SL_HALF_U, SL_HALF_S: access_size = SZ_HALF;
            default:              access_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Data-bus interface between the MEM-stage engine (master) and the data
// memory / bus slave.
//   bus_req   master -> slave  request, held high until the ack cycle
//   bus_we    master -> slave  1 = write
//   bus_addr  master -> slave  word address
//   bus_be    master -> slave  byte enables
//   bus_wdata master -> slave  lane-replicated store data
//   bus_ack   slave -> master  one-cycle completion
//   bus_rdata slave -> master  read word, valid with bus_ack
//
// Handshake: a transfer completes on the rising edge where bus_req and
// bus_ack are both high. While bus_req is high, bus_we/addr/be/wdata are
// stable. bus_ack seen while bus_req is low carries no meaning and is
// dropped by the master.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_lane_gen.sv
// mem_lane_gen
// Combinational alignment check plus byte-enable and store-lane generation.
//   sl_ctrl_i    access size (SLCtrl encoding)
//   addr_lo_i    Addr[1:0]
//   wdata_i      right-aligned store data
//   we_i         1 = store
//   misaligned_o access violates its natural alignment
//   be_o         byte enables (all ones for loads)
//   wdata_o      store data replicated onto every lane
module mem_lane_gen
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  sl_ctrl_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);
    size_t size;

    always_comb begin
        size         = access_size(sl_ctrl_i);
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        case (size)
            SZ_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                if (we_i) be_o = 4'b0001 << addr_lo_i;
            end
            SZ_HALF: begin
                misaligned_o = addr_lo_i[0];
                wdata_o      = {2{wdata_i[15:0]}};
                if (we_i) be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage load/store engine feeding the MEM/WB register. Runs one
// req/ack bus transaction per memory instruction and stalls the front of
// the pipeline while it is outstanding.
//   clk, reset    clock; asynchronous active-high reset
//   ExcClr        synchronous flush, aborts the current op
//   MemValid/MemWE/SLCtrl/Addr/WData   memory op from EX/MEM
//   bus           data-bus master port
//   Stall         freeze PC/IF/ID/EX and EX/MEM
//   DMDataR       captured raw read word (0 after a store or bus error)
//   ExcValid/ExcCode/BadVAddr  memory exception for the MEM-stage op
//   dbg_state_o   FSM state
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ExcClr,
    input  logic                MemValid,
    input  logic                MemWE,
    input  logic [2:0]          SLCtrl,
    input  logic [31:0]         Addr,
    input  logic [31:0]         WData,
    mem_access_unit_if.master   bus,
    output logic                Stall,
    output logic [31:0]         DMDataR,
    output logic                ExcValid,
    output logic [4:0]          ExcCode,
    output logic [31:0]         BadVAddr,
    output state_t              dbg_state_o
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dmdata_q, dmdata_d;

    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    mem_lane_gen u_lane_gen (
        .sl_ctrl_i    (SLCtrl),
        .addr_lo_i    (Addr[1:0]),
        .wdata_i      (WData),
        .we_i         (MemWE),
        .misaligned_o (misaligned),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            dmdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            dmdata_q <= dmdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        dmdata_d = dmdata_q;
        Stall    = 1'b0;
        ExcValid = 1'b0;
        ExcCode  = '0;
        BadVAddr = '0;

        case (state_q)
            ST_IDLE: begin
                if (MemValid && !ExcClr) begin
                    if (misaligned) begin
                        // Address error is reported without touching the bus.
                        ExcValid = 1'b1;
                        ExcCode  = MemWE ? EXC_ADES : EXC_ADEL;
                        BadVAddr = Addr;
                    end else begin
                        // Reset gating lets an async reset drop Stall at once
                        // even while the frozen pipeline still holds MemValid.
                        Stall   = !reset;
                        state_d = ST_REQ;
                        cnt_d   = '0;
                        we_d    = MemWE;
                        addr_d  = Addr;
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                    end
                end
            end
            ST_REQ: begin
                Stall = 1'b1;
                if (bus.bus_ack) begin
                    state_d  = ST_DONE;
                    dmdata_d = we_q ? 32'h0 : bus.bus_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_ERR;
                    dmdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                ExcValid = 1'b1;
                ExcCode  = EXC_DBE;
                BadVAddr = addr_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush beats every transition, including a same-cycle ack capture.
        if (ExcClr) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            dmdata_d = dmdata_q;
        end
    end

    assign bus.bus_req   = (state_q == ST_REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign DMDataR       = dmdata_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        ExcClr;
    logic        MemValid;
    logic        MemWE;
    logic [2:0]  SLCtrl;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Stall;
    logic [31:0] DMDataR;
    logic        ExcValid;
    logic [4:0]  ExcCode;
    logic [31:0] BadVAddr;
    state_t      dbg_state;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ExcClr      (ExcClr),
        .MemValid    (MemValid),
        .MemWE       (MemWE),
        .SLCtrl      (SLCtrl),
        .Addr        (Addr),
        .WData       (WData),
        .bus         (bus),
        .Stall       (Stall),
        .DMDataR     (DMDataR),
        .ExcValid    (ExcValid),
        .ExcCode     (ExcCode),
        .BadVAddr    (BadVAddr),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    logic [3:0]  seen_be;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic        seen_we;
    int          stall_n;
    int          req_n;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op and act as the bus slave; waits < 0 means never ack.
    // Returns at the negedge of the first non-stalled cycle (DONE or ERR).
    task automatic run_op(input logic we, input logic [2:0] sl, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd);
        step();
        MemValid = 1'b1;
        MemWE    = we;
        SLCtrl   = sl;
        Addr     = addr;
        WData    = wd;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        stall_n = 0;
        req_n   = 0;
        @(negedge clk);
        while (Stall && stall_n < 40) begin
            stall_n++;
            step();
            if (bus.bus_req) begin
                req_n++;
                seen_be    = bus.bus_be;
                seen_addr  = bus.bus_addr;
                seen_wdata = bus.bus_wdata;
                seen_we    = bus.bus_we;
                bus.bus_ack   = (waits >= 0) && (req_n == waits + 1);
                bus.bus_rdata = bus.bus_ack ? rd : 32'h0;
            end else begin
                bus.bus_ack   = 1'b0;
                bus.bus_rdata = 32'h0;
            end
            @(negedge clk);
        end
    endtask

    // Pipeline advances after the DONE/ERR cycle: no op in the next cycle.
    task automatic end_op();
        step();
        MemValid      = 1'b0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        ExcClr = 1'b0;
        MemValid = 1'b0;
        MemWE = 1'b0;
        SLCtrl = 3'd0;
        Addr = 32'h0;
        WData = 32'h0;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = 32'h0;
        seen_be = '0;
        seen_addr = '0;
        seen_wdata = '0;
        seen_we = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.bus_req), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_dmdata", DMDataR, 32'h0);
        chk("rst_excvalid", 32'(ExcValid), 32'd0);
        chk("rst_be", 32'(bus.bus_be), 32'h0);
        chk("rst_addr", bus.bus_addr, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;

        // lw 0x1004, zero wait
        run_op(1'b0, SL_WORD, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        chk("lw_stall_cycles", 32'(stall_n), 32'd2);
        chk("lw_addr", seen_addr, 32'h0000_1004);
        chk("lw_be", 32'(seen_be), 32'hF);
        chk("lw_we", 32'(seen_we), 32'd0);
        chk("lw_done_state", 32'(dbg_state), 32'(ST_DONE));
        chk("lw_dmdata", DMDataR, exp_q.pop_front());
        end_op();
        chk("lw_hold_dmdata", DMDataR, 32'hDEAD_BEEF);
        chk("lw_idle_stall", 32'(Stall), 32'd0);

        // sb 0x2003, three waits
        run_op(1'b1, SL_BYTE_U, 32'h0000_2003, 32'h1234_5678, 3, 32'hFFFF_FFFF);
        chk("sb_stall_cycles", 32'(stall_n), 32'd5);
        chk("sb_be", 32'(seen_be), 32'h8);
        chk("sb_wdata", seen_wdata, 32'h7878_7878);
        chk("sb_addr", seen_addr, 32'h0000_2000);
        chk("sb_we", 32'(seen_we), 32'd1);
        chk("sb_dmdata", DMDataR, 32'h0);
        end_op();

        // sh 0x2002
        run_op(1'b1, SL_HALF_U, 32'h0000_2002, 32'h1234_5678, 0, 32'h0);
        chk("sh_be", 32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wdata, 32'h5678_5678);
        chk("sh_stall_cycles", 32'(stall_n), 32'd2);
        end_op();

        // sw with SLCtrl=7 behaves as word
        run_op(1'b1, 3'd7, 32'h0000_2004, 32'hA5A5_1234, 1, 32'h0);
        chk("sw7_be", 32'(seen_be), 32'hF);
        chk("sw7_wdata", seen_wdata, 32'hA5A5_1234);
        chk("sw7_stall_cycles", 32'(stall_n), 32'd3);
        end_op();

        // misaligned lh 0x3001 and sw 0x3002
        step();
        MemValid = 1'b1; MemWE = 1'b0; SLCtrl = SL_HALF_S; Addr = 32'h0000_3001;
        @(negedge clk);
        chk("adel_valid", 32'(ExcValid), 32'd1);
        chk("adel_code", 32'(ExcCode), 32'd4);
        chk("adel_badv", BadVAddr, 32'h0000_3001);
        chk("adel_stall", 32'(Stall), 32'd0);
        chk("adel_req", 32'(bus.bus_req), 32'd0);
        step();
        MemWE = 1'b1; SLCtrl = SL_WORD; Addr = 32'h0000_3002;
        @(negedge clk);
        chk("ades_req_prev", 32'(bus.bus_req), 32'd0);
        chk("ades_code", 32'(ExcCode), 32'd5);
        chk("ades_badv", BadVAddr, 32'h0000_3002);
        step();
        MemValid = 1'b0;
        @(negedge clk);
        chk("ades_clear", 32'(ExcValid), 32'd0);

        // timeout: lh 0x4006, no ack
        run_op(1'b0, SL_HALF_U, 32'h0000_4006, 32'h0, -1, 32'h0);
        chk("to_req_cycles", 32'(req_n), 32'd4);
        chk("to_stall_cycles", 32'(stall_n), 32'd5);
        chk("to_excvalid", 32'(ExcValid), 32'd1);
        chk("to_code", 32'(ExcCode), 32'd7);
        chk("to_badv", BadVAddr, 32'h0000_4006);
        chk("to_bus_addr", seen_addr, 32'h0000_4004);
        chk("to_dmdata", DMDataR, 32'h0);
        chk("to_stall", 32'(Stall), 32'd0);
        end_op();
        chk("to_after_exc", 32'(ExcValid), 32'd0);
        chk("to_after_state", 32'(dbg_state), 32'(ST_IDLE));

        // ExcClr in the second REQ cycle, late ack ignored
        step();
        MemValid = 1'b1; MemWE = 1'b0; SLCtrl = SL_WORD; Addr = 32'h0000_5000;
        @(negedge clk);
        chk("clr_idle_stall", 32'(Stall), 32'd1);
        step();
        @(negedge clk);
        chk("clr_req1", 32'(bus.bus_req), 32'd1);
        step();
        ExcClr = 1'b1;
        @(negedge clk);
        chk("clr_req2", 32'(bus.bus_req), 32'd1);
        step();
        ExcClr = 1'b0; MemValid = 1'b0;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("clr_req_drop", 32'(bus.bus_req), 32'd0);
        chk("clr_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("clr_stall", 32'(Stall), 32'd0);
        step();
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
        @(negedge clk);
        chk("clr_late_ack_dmdata", DMDataR, 32'h0);
        chk("clr_late_ack_state", 32'(dbg_state), 32'(ST_IDLE));

        // lh 0x1006 signed, one wait: raw word delivered
        run_op(1'b0, SL_HALF_S, 32'h0000_1006, 32'h0, 1, 32'hCAFE_F00D);
        chk("lh_be", 32'(seen_be), 32'hF);
        chk("lh_stall_cycles", 32'(stall_n), 32'd3);
        chk("lh_dmdata", DMDataR, 32'hCAFE_F00D);
        end_op();

        // async reset mid-REQ
        step();
        MemValid = 1'b1; MemWE = 1'b0; SLCtrl = SL_WORD; Addr = 32'h0000_6000;
        step();
        @(negedge clk);
        chk("ar_req_before", 32'(bus.bus_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_req_now", 32'(bus.bus_req), 32'd0);
        chk("ar_stall_now", 32'(Stall), 32'd0);
        chk("ar_dmdata", DMDataR, 32'h0);
        MemValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // first op after reset: lbu 0x7003, two waits
        run_op(1'b0, SL_BYTE_U, 32'h0000_7003, 32'h0, 2, 32'h89AB_CDEF);
        exp_q.push_back(32'h89AB_CDEF);
        chk("post_rst_stall_cycles", 32'(stall_n), 32'd4);
        chk("post_rst_addr", seen_addr, 32'h0000_7000);
        chk("post_rst_be", 32'(seen_be), 32'hF);
        chk("post_rst_dmdata", DMDataR, exp_q.pop_front());
        end_op();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
